mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers, sitting in the execute stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU operands from the execute-stage register outputs and runs for a fixed number of cycles. While it runs, it holds `busy` high so the hazard logic can stall the fetch and decode registers and flush the execute register. Results land in HI/LO for later MFHI/MFLO reads, which travel down the memory and writeback registers like ALU results.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (reset asserted when 0).
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`  in  `WIDTH`  rs operand (multiplicand / dividend).
- `b`  in  `WIDTH`  rt operand (multiplier / divisor).
- `flush`  in  1  abort in-flight operation.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wd`  in  `WIDTH`  MTHI/MTLO write data.
- `busy`  out  1  high whenever state is not IDLE (combinational from state).
- `done`  out  1  registered one-cycle pulse when HI/LO receive a new result.
- `hi`  out  `WIDTH`  HI register (product high half / remainder).
- `lo`  out  `WIDTH`  LO register (product low half / quotient).

## Operation
- States: IDLE, RUN, FIX. Reset enters IDLE and zeroes `hi`, `lo`, `done`, the iteration counter, and all working registers.
- IDLE with `start` = 1 and `flush` = 0:
  - Latch `op`.
  - For signed ops, latch the sign bits of `a` and `b` and replace each operand with its magnitude.
  - Go to RUN with the counter at `WIDTH`-1.
- RUN performs one iteration per cycle.
  - Multiply: radix-2 shift-add into a 2×`WIDTH` accumulator.
  - Divide: restoring shift-subtract. The remainder register is `WIDTH`+1 bits so the subtract borrow is not lost.
  - When the counter reaches 0, the next state is FIX.
- FIX:
  - Apply sign correction. MULT product is negated if sign(a)^sign(b). DIV quotient is negated if sign(a)^sign(b); DIV remainder is negated if sign(a).
  - Write `hi` and `lo`, set `done`, and go to IDLE.
- Divide by zero (`b` = 0, any divide op):
  - Full latency still applies and sign correction is skipped.
  - `lo` = all ones and `hi` = original unsigned bit pattern of `a`.
- DIV with most-negative dividend and divisor −1 gives `lo` = 0x80000000 and `hi` = 0; the result wraps and no exception is raised.
- `start` while `busy` is ignored.
- `flush` in RUN or FIX:
  - Return to IDLE on the next edge.
  - `hi`/`lo` are left unchanged and no `done` is issued.
  - `flush` together with `start` in IDLE: `flush` wins and nothing launches.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE and write `wd` on the edge.
  - Ignored while `busy`; the hazard logic stalls MTHI/MTLO during that time.
  - If `start` and `hi_we`/`lo_we` occur in the same IDLE cycle, both take effect and the later FIX overwrites.
- `reset` asserted mid-operation: immediately IDLE, all outputs 0, and the operation is lost.

## Timing
- Call the edge that samples `start` E0.
- RUN occupies the `WIDTH` cycles E0..E`WIDTH`, and FIX occupies cycle E`WIDTH`..E`WIDTH`+1.
- `hi`/`lo` update at E`WIDTH`+1. `done` is high for exactly the one cycle following E`WIDTH`+1, coincident with the new `hi`/`lo`.
- `busy` is high from E0 until E`WIDTH`+1, which is `WIDTH`+1 cycles (33 at default).
- Back-to-back operation: a new `start` can be accepted at E`WIDTH`+1 (the cycle `done` is high), since the state is IDLE.
- `hi`/`lo` are constant at all times other than the result write and an accepted MTHI/MTLO edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `done` high for exactly 1 cycle; `busy` high for 33 cycles.
- MULT −3 × 7 (0xFFFFFFFD, 0x00000007) → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → `hi` = 0x40000000, `lo` = 0.
- DIV −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF; DIVU 100 / 7 → `lo` = 14, `hi` = 2; DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- DIVU 100 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000064 after full 33 cycles.
- Preload via MTHI/MTLO `wd` = 0xA5A5A5A5. Then:
  - Start MULTU 5×5 and pulse `flush` at cycle 10: `busy` low next cycle, `hi`/`lo` remain 0xA5A5A5A5, no `done`.
  - Pulse `start` + `flush` together: no launch.
  - `hi_we` while `busy`: ignored.
- Assert `reset` (low) at cycle 15 of a DIVU: `busy`, `done`, `hi`, `lo` = 0 immediately. After release, a fresh MULTU 3×4 yields `lo` = 12, `hi` = 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit with architectural HI/LO registers, placed in
// the execute stage beside the ALU. One radix-2 iteration per cycle, WIDTH
// iterations, then one sign-fix cycle that writes HI/LO.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   start         launch request, sampled only while idle
//   op[1:0]       00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b          rs / rt operands
//   flush         abort the in-flight operation (wins over start)
//   hi_we, lo_we  MTHI / MTLO write enables, honoured only while idle
//   wd            MTHI / MTLO write data
//   busy          high whenever the unit is not idle
//   done          one-cycle pulse coincident with new HI/LO
//   hi, lo        HI (product high / remainder), LO (product low / quotient)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [1:0]           op_r;
  logic                 sign_a;
  logic                 sign_b;
  logic                 div_zero;
  logic [CNT_W-1:0]     cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds unconsumed dividend bits with quotient bits
  // shifting in from the bottom; the high half is idle.
  logic [2*WIDTH-1:0]   acc;
  // Shifted partial remainder; one extra bit because the shifted value can
  // reach 2*divisor-1 before the trial subtract.
  logic [WIDTH:0]       rem;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]     opnd;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  logic             in_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_keep;
  logic [WIDTH-1:0] rem_fixed;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign busy = (state != IDLE);

  // Launch-time operand conditioning: signed ops work on magnitudes.
  assign in_signed = ~op[0];
  assign mag_a     = (in_signed && a[WIDTH-1]) ? neg_w(a) : a;
  assign mag_b     = (in_signed && b[WIDTH-1]) ? neg_w(b) : b;

  // One iteration of shift-add multiply and restoring divide.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_diff = rem - {1'b0, opnd};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_keep = div_ok ? div_diff[WIDTH-1:0] : rem[WIDTH-1:0];

  // Sign correction. For divide-by-zero the remainder register holds |a|,
  // so negating it for a negative signed dividend restores a's original bit
  // pattern -- the same expression as the normal remainder fix.
  assign rem_fixed = sign_a ? neg_w(rem[WIDTH-1:0]) : rem[WIDTH-1:0];

  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (op_r[1]) begin
      fix_hi = rem_fixed;
      if (div_zero)
        fix_lo = {WIDTH{1'b1}};
      else if (sign_a ^ sign_b)
        fix_lo = neg_w(acc[WIDTH-1:0]);
    end else if (sign_a ^ sign_b) begin
      {fix_hi, fix_lo} = neg_2w(acc);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_r     <= 2'b00;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start && !flush) begin
            op_r     <= op;
            sign_a   <= in_signed & a[WIDTH-1];
            sign_b   <= in_signed & b[WIDTH-1];
            div_zero <= op[1] & (b == '0);
            cnt      <= CNT_W'(WIDTH - 1);
            state    <= RUN;
            if (op[1]) begin
              // Pre-shift the first dividend bit into the remainder.
              opnd <= mag_b;
              rem  <= {{WIDTH{1'b0}}, mag_a[WIDTH-1]};
              acc  <= {{WIDTH{1'b0}}, mag_a[WIDTH-2:0], 1'b0};
            end else begin
              opnd <= mag_a;
              rem  <= '0;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end

        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (op_r[1]) begin
              acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ok};
              // Last iteration keeps the final remainder unshifted.
              if (cnt == '0)
                rem <= {1'b0, div_keep};
              else
                rem <= {div_keep, acc[WIDTH-1]};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            if (cnt == '0)
              state <= FIX;
            else
              cnt <= cnt - 1'b1;
          end
        end

        FIX: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return 64'(ux * uy);
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clock) begin
    if (reset && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("hi", 64'(hi), 64'(sb_exp[63:32]));
        check("lo", 64'(lo), 64'(sb_exp[31:0]));
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  // Full operation with latency and done-width checks.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int cyc;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(model(o, x, y));
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clock);
    end
    check("busy_cycles", 64'(cyc), 64'd33);
    check("done_at_idle", 64'(done), 64'd1);
    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  logic [1:0]  t_op [9] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10};
  logic [31:0] t_a  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                            32'd100, 32'h8000_0000, 32'd100, 32'hFFFF_FFFB, 32'd7};
  logic [31:0] t_b  [9] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                            32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE};

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) do_op(t_op[i], t_a[i], t_b[i]);

    for (int i = 0; i < 12; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 20));
        2: r_b = -32'($urandom_range(1, 20));
        default: r_b = $urandom;
      endcase
      do_op(r_op, r_a, r_b);
    end

    // MTHI/MTLO preload.
    @(negedge clock);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_A5A5;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mt_lo", 64'(lo), 64'hA5A5_A5A5);

    // Flush mid-run: no result, no done.
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clock);
    check("flush_hi", 64'(hi), 64'hA5A5_A5A5);
    check("flush_lo", 64'(lo), 64'hA5A5_A5A5);

    // Start and flush together: nothing launches.
    start = 1'b1; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);

    // MTHI/MTLO while busy are ignored.
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    sb_q.push_back(model(2'b01, 32'd5, 32'd5));
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234_5678;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("busy_mt_hi", 64'(hi), 64'hA5A5_A5A5);
    check("busy_mt_lo", 64'(lo), 64'hA5A5_A5A5);
    wait_idle("busy_mt_idle");
    @(negedge clock);

    // Start together with MTHI/MTLO: write lands now, result overwrites later.
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1111_1111;
    sb_q.push_back(model(2'b01, 32'd6, 32'd7));
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("start_mt_hi", 64'(hi), 64'h1111_1111);
    check("start_mt_busy", 64'(busy), 64'd1);
    wait_idle("start_mt_idle");
    @(negedge clock);

    // Reset in the middle of a DIVU.
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    do_op(2'b01, 32'd3, 32'd4);

    repeat (3) @(negedge clock);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
